// File: rtl/sdrlib_stream_pkg.sv
// Shared framing definitions for the combined stream link (combiner and splitter).
// Header word: flag in the MSB, stream id just below it, payload length in the low bits.
package sdrlib_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_ERROR   = 2'd2
   } stream_state_t;

   // Reserved word the combiner emits on an internal fault; length 127 makes it an illegal header.
   localparam logic [31:0] ERRORCODE = 32'hFFFF_FFFF;

   function automatic int unsigned flag_pos(input int unsigned wdth);
      return wdth - 1;
   endfunction

   function automatic int unsigned id_lsb(input int unsigned wdth, input int unsigned log_n);
      return wdth - 1 - log_n;
   endfunction

endpackage

// File: rtl/stream_header_decode.sv
// Combinational header field extraction and legality check for one combined-stream word.
module stream_header_decode
   import sdrlib_stream_pkg::*;
#(
   parameter int unsigned N_STREAMS         = 2,
   parameter int unsigned LOG_N_STREAMS     = 1,
   parameter int unsigned WDTH              = 32,
   parameter int unsigned MAX_PACKET_LENGTH = 64,
   parameter int unsigned MSG_LENGTH_WIDTH  = 7
) (
   input  logic [WDTH-1:0]             in_data,
   output logic                        flag,
   output logic [LOG_N_STREAMS-1:0]    id,
   output logic [MSG_LENGTH_WIDTH-1:0] length,
   output logic                        header_legal
);

   localparam int unsigned FLAG_BIT = flag_pos(WDTH);
   localparam int unsigned ID_LSB   = id_lsb(WDTH, LOG_N_STREAMS);

   always_comb begin
      flag         = in_data[FLAG_BIT];
      id           = in_data[ID_LSB +: LOG_N_STREAMS];
      length       = in_data[MSG_LENGTH_WIDTH-1:0];
      header_legal = flag
                     && (32'(id) < 32'(N_STREAMS))
                     && (32'(length) <= 32'(MAX_PACKET_LENGTH));
   end

endmodule

// File: rtl/message_stream_splitter.sv
// Splits a combined header/payload word stream into N_STREAMS one-hot qualified streams.
// MESSAGE_STREAM_SPLITTER_RESYNC_EN: pulse error and resynchronise instead of locking in ERROR.
module message_stream_splitter
   import sdrlib_stream_pkg::*;
#(
   parameter int unsigned N_STREAMS         = 2,
   parameter int unsigned LOG_N_STREAMS     = 1,
   parameter int unsigned WDTH              = 32,
   parameter int unsigned MAX_PACKET_LENGTH = 64,
   parameter int unsigned MSG_LENGTH_WIDTH  = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WDTH-1:0]      in_data,
   input  logic                 in_nd,
   output logic [WDTH-1:0]      out_data,
   output logic [N_STREAMS-1:0] out_nd,
   output logic                 error
);

   stream_state_t                state, state_nxt;
   logic [MSG_LENGTH_WIDTH-1:0]  remaining, remaining_nxt;
   logic [LOG_N_STREAMS-1:0]     id_q, id_nxt;
   logic [WDTH-1:0]              data_nxt;
   logic [N_STREAMS-1:0]         nd_nxt;
   logic                         error_nxt;

   logic                         hdr_flag;
   logic [LOG_N_STREAMS-1:0]     hdr_id;
   logic [MSG_LENGTH_WIDTH-1:0]  hdr_len;
   logic                         hdr_legal;
   logic                         hdr_bad;

   stream_header_decode #(
      .N_STREAMS         (N_STREAMS),
      .LOG_N_STREAMS     (LOG_N_STREAMS),
      .WDTH              (WDTH),
      .MAX_PACKET_LENGTH (MAX_PACKET_LENGTH),
      .MSG_LENGTH_WIDTH  (MSG_LENGTH_WIDTH)
   ) u_decode (
      .in_data      (in_data),
      .flag         (hdr_flag),
      .id           (hdr_id),
      .length       (hdr_len),
      .header_legal (hdr_legal)
   );

   always_comb hdr_bad = !hdr_flag || !hdr_legal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         remaining <= '0;
         id_q      <= '0;
         out_data  <= '0;
         out_nd    <= '0;
         error     <= 1'b0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         id_q      <= id_nxt;
         out_data  <= data_nxt;
         out_nd    <= nd_nxt;
         error     <= error_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      id_nxt        = id_q;
      case (state)
         ST_IDLE: begin
            if (in_nd) begin
               if (hdr_bad) begin
`ifdef MESSAGE_STREAM_SPLITTER_RESYNC_EN
                  state_nxt = ST_IDLE;
`else
                  state_nxt = ST_ERROR;
`endif
               end else if (hdr_len != '0) begin
                  state_nxt     = ST_PAYLOAD;
                  remaining_nxt = hdr_len;
                  id_nxt        = hdr_id;
               end
            end
         end
         ST_PAYLOAD: begin
            if (in_nd) begin
               remaining_nxt = remaining - MSG_LENGTH_WIDTH'(1);
               if (remaining == MSG_LENGTH_WIDTH'(1)) begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = state;
      endcase
   end

   always_comb begin
      data_nxt = out_data;
      nd_nxt   = '0;
      if (state == ST_PAYLOAD && in_nd) begin
         data_nxt = in_data;
         nd_nxt   = N_STREAMS'(1) << id_q;
      end
`ifdef MESSAGE_STREAM_SPLITTER_RESYNC_EN
      error_nxt = (state == ST_IDLE) && in_nd && hdr_bad;
`else
      error_nxt = (state_nxt == ST_ERROR);
`endif
   end

endmodule

// File: tb/tb_message_stream_splitter.sv
// Randomised and directed bench for message_stream_splitter; expectations come from packet-level stimulus.
module tb_message_stream_splitter;

   localparam int unsigned N    = 2;
   localparam int unsigned LOG  = 1;
   localparam int unsigned W    = 32;
   localparam int unsigned MAXL = 64;
   localparam int unsigned MLW  = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [W-1:0]  in_data = '0;
   logic          in_nd = 1'b0;
   logic [W-1:0]  out_data;
   logic [N-1:0]  out_nd;
   logic          error;

   int checks = 0;
   int fails  = 0;

   logic [W-1:0] q_word[$];
   bit           q_nd[$];
   logic [N-1:0] q_exp_nd[$];
   logic [W-1:0] q_exp_data[$];
   bit           q_exp_err[$];

   message_stream_splitter #(
      .N_STREAMS         (N),
      .LOG_N_STREAMS     (LOG),
      .WDTH              (W),
      .MAX_PACKET_LENGTH (MAXL),
      .MSG_LENGTH_WIDTH  (MLW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_nd    (in_nd),
      .out_data (out_data),
      .out_nd   (out_nd),
      .error    (error)
   );

   always #5 clk = ~clk;

   task automatic clear_q();
      q_word.delete(); q_nd.delete(); q_exp_nd.delete(); q_exp_data.delete(); q_exp_err.delete();
   endtask

   task automatic push(input logic [W-1:0] w, input bit nd, input logic [N-1:0] en,
                       input logic [W-1:0] ed, input bit ee);
      q_word.push_back(w); q_nd.push_back(nd); q_exp_nd.push_back(en);
      q_exp_data.push_back(ed); q_exp_err.push_back(ee);
   endtask

   task automatic push_idle(input int n, input bit ee);
      for (int k = 0; k < n; k++) push('0, 1'b0, '0, '0, ee);
   endtask

   // A legal packet: header is silent, each payload word reappears on its stream one cycle later.
   task automatic push_pkt(input int id, input int len, input int gapmax);
      logic [W-1:0] d;
      push(32'h8000_0000 | (32'(id) << 30) | 32'(len), 1'b1, '0, '0, 1'b0);
      for (int k = 0; k < len; k++) begin
         push_idle($urandom_range(gapmax, 0), 1'b0);
         d = $urandom;
         push(d, 1'b1, N'(1) << id, d, 1'b0);
      end
   endtask

   task automatic step(input logic [W-1:0] w, input bit nd);
      in_data = w;
      in_nd   = nd;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_nd = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      checks++; if (out_nd !== '0)   begin fails++; $display("FAIL reset out_nd got %b want 0", out_nd); end
      checks++; if (out_data !== '0) begin fails++; $display("FAIL reset out_data got %h want 0", out_data); end
      checks++; if (error !== 1'b0)  begin fails++; $display("FAIL reset error got %b want 0", error); end
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_simple();
      clear_q();
      push(32'h8000_0003, 1, '0, '0, 0);
      push(32'h11, 1, 2'b01, 32'h11, 0);
      push(32'h22, 1, 2'b01, 32'h22, 0);
      push(32'h33, 1, 2'b01, 32'h33, 0);
      push_idle(2, 0);
      for (int i = 0; i < q_word.size(); i++) begin
         step(q_word[i], q_nd[i]);
         checks++; if (out_nd !== q_exp_nd[i]) begin fails++; $display("FAIL simple out_nd[%0d] got %b want %b", i, out_nd, q_exp_nd[i]); end
         checks++; if (error !== q_exp_err[i]) begin fails++; $display("FAIL simple error[%0d] got %b want %b", i, error, q_exp_err[i]); end
         if (q_exp_nd[i] != '0) begin
            checks++; if (out_data !== q_exp_data[i]) begin fails++; $display("FAIL simple out_data[%0d] got %h want %h", i, out_data, q_exp_data[i]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      clear_q();
      push(32'hC000_0002, 1, '0, '0, 0);
      push(32'hA, 1, 2'b10, 32'hA, 0);
      push(32'hB, 1, 2'b10, 32'hB, 0);
      push(32'h8000_0001, 1, '0, '0, 0);
      push(32'hC, 1, 2'b01, 32'hC, 0);
      push_pkt(1, MAXL, 0);
      push_pkt(0, 1, 0);
      push_idle(1, 0);
      for (int i = 0; i < q_word.size(); i++) begin
         step(q_word[i], q_nd[i]);
         checks++; if (out_nd !== q_exp_nd[i]) begin fails++; $display("FAIL b2b out_nd[%0d] got %b want %b", i, out_nd, q_exp_nd[i]); end
         checks++; if (error !== q_exp_err[i]) begin fails++; $display("FAIL b2b error[%0d] got %b want %b", i, error, q_exp_err[i]); end
         if (q_exp_nd[i] != '0) begin
            checks++; if (out_data !== q_exp_data[i]) begin fails++; $display("FAIL b2b out_data[%0d] got %h want %h", i, out_data, q_exp_data[i]); end
         end
      end
   endtask

   task automatic test_gaps_zero_len();
      clear_q();
      push(32'h8000_0002, 1, '0, '0, 0);
      push(32'h1, 1, 2'b01, 32'h1, 0);
      push_idle(5, 0);
      push(32'h2, 1, 2'b01, 32'h2, 0);
      push(32'h8000_0000, 1, '0, '0, 0);
      push(32'h8000_0001, 1, '0, '0, 0);
      push(32'h7, 1, 2'b01, 32'h7, 0);
      push_idle(2, 0);
      for (int i = 0; i < q_word.size(); i++) begin
         step(q_word[i], q_nd[i]);
         checks++; if (out_nd !== q_exp_nd[i]) begin fails++; $display("FAIL gaps out_nd[%0d] got %b want %b", i, out_nd, q_exp_nd[i]); end
         checks++; if (error !== q_exp_err[i]) begin fails++; $display("FAIL gaps error[%0d] got %b want %b", i, error, q_exp_err[i]); end
         if (q_exp_nd[i] != '0) begin
            checks++; if (out_data !== q_exp_data[i]) begin fails++; $display("FAIL gaps out_data[%0d] got %h want %h", i, out_data, q_exp_data[i]); end
         end
      end
   endtask

   task automatic test_random();
      int len;
      clear_q();
      for (int p = 0; p < 40; p++) begin
         case ($urandom_range(7, 0))
            0:       len = 0;
            1:       len = 1;
            2:       len = MAXL;
            default: len = $urandom_range(20, 1);
         endcase
         push_pkt($urandom_range(N - 1, 0), len, $urandom_range(2, 0));
         push_idle($urandom_range(1, 0), 0);
      end
      push_idle(1, 0);
      for (int i = 0; i < q_word.size(); i++) begin
         step(q_word[i], q_nd[i]);
         checks++; if (out_nd !== q_exp_nd[i]) begin fails++; $display("FAIL random out_nd[%0d] got %b want %b", i, out_nd, q_exp_nd[i]); end
         checks++; if (error !== q_exp_err[i]) begin fails++; $display("FAIL random error[%0d] got %b want %b", i, error, q_exp_err[i]); end
         if (q_exp_nd[i] != '0) begin
            checks++; if (out_data !== q_exp_data[i]) begin fails++; $display("FAIL random out_data[%0d] got %h want %h", i, out_data, q_exp_data[i]); end
         end
      end
   endtask

   task automatic test_reset_mid_packet();
      clear_q();
      push(32'h8000_0004, 1, '0, '0, 0);
      push(32'h41, 1, 2'b01, 32'h41, 0);
      push(32'h42, 1, 2'b01, 32'h42, 0);
      for (int i = 0; i < q_word.size(); i++) begin
         step(q_word[i], q_nd[i]);
         checks++; if (out_nd !== q_exp_nd[i]) begin fails++; $display("FAIL midrst out_nd[%0d] got %b want %b", i, out_nd, q_exp_nd[i]); end
      end
      in_nd = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_nd !== '0)   begin fails++; $display("FAIL midrst async out_nd got %b want 0", out_nd); end
      checks++; if (out_data !== '0) begin fails++; $display("FAIL midrst async out_data got %h want 0", out_data); end
      checks++; if (error !== 1'b0)  begin fails++; $display("FAIL midrst async error got %b want 0", error); end
      @(posedge clk);
      #2 rst_n = 1'b1;
      clear_q();
      push(32'h8000_0001, 1, '0, '0, 0);
      push(32'h5, 1, 2'b01, 32'h5, 0);
      push_idle(1, 0);
      for (int i = 0; i < q_word.size(); i++) begin
         step(q_word[i], q_nd[i]);
         checks++; if (out_nd !== q_exp_nd[i]) begin fails++; $display("FAIL midrst2 out_nd[%0d] got %b want %b", i, out_nd, q_exp_nd[i]); end
         checks++; if (error !== q_exp_err[i]) begin fails++; $display("FAIL midrst2 error[%0d] got %b want %b", i, error, q_exp_err[i]); end
         if (q_exp_nd[i] != '0) begin
            checks++; if (out_data !== q_exp_data[i]) begin fails++; $display("FAIL midrst2 out_data[%0d] got %h want %h", i, out_data, q_exp_data[i]); end
         end
      end
   endtask

   task automatic test_bad_framing();
      clear_q();
`ifdef MESSAGE_STREAM_SPLITTER_RESYNC_EN
      push(32'h0000_0005, 1, '0, '0, 1);
      push(32'h8000_0001, 1, '0, '0, 0);
      push(32'h9, 1, 2'b01, 32'h9, 0);
      push(32'h8000_0041, 1, '0, '0, 1);
      push_idle(1, 0);
      push(32'hFFFF_FFFF, 1, '0, '0, 1);
      push(32'h0000_0001, 1, '0, '0, 1);
      push_pkt(1, 3, 1);
      push_idle(1, 0);
`else
      push(32'h0000_0005, 1, '0, '0, 1);
      push(32'h8000_0001, 1, '0, '0, 1);
      push(32'h9, 1, '0, '0, 1);
      push_idle(3, 1);
`endif
      for (int i = 0; i < q_word.size(); i++) begin
         step(q_word[i], q_nd[i]);
         checks++; if (out_nd !== q_exp_nd[i]) begin fails++; $display("FAIL bad out_nd[%0d] got %b want %b", i, out_nd, q_exp_nd[i]); end
         checks++; if (error !== q_exp_err[i]) begin fails++; $display("FAIL bad error[%0d] got %b want %b", i, error, q_exp_err[i]); end
         if (q_exp_nd[i] != '0) begin
            checks++; if (out_data !== q_exp_data[i]) begin fails++; $display("FAIL bad out_data[%0d] got %h want %h", i, out_data, q_exp_data[i]); end
         end
      end
      do_reset();
      clear_q();
`ifdef MESSAGE_STREAM_SPLITTER_RESYNC_EN
      push(32'h8000_0041, 1, '0, '0, 1);
      push_idle(2, 0);
`else
      push(32'h8000_0041, 1, '0, '0, 1);
      push_pkt(0, 2, 0);
      for (int k = 0; k < q_exp_err.size(); k++) begin
         q_exp_err[k] = 1'b1;
         q_exp_nd[k]  = '0;
      end
`endif
      for (int i = 0; i < q_word.size(); i++) begin
         step(q_word[i], q_nd[i]);
         checks++; if (out_nd !== q_exp_nd[i]) begin fails++; $display("FAIL len65 out_nd[%0d] got %b want %b", i, out_nd, q_exp_nd[i]); end
         checks++; if (error !== q_exp_err[i]) begin fails++; $display("FAIL len65 error[%0d] got %b want %b", i, error, q_exp_err[i]); end
      end
      do_reset();
      checks++; if (error !== 1'b0) begin fails++; $display("FAIL bad recover error got %b want 0", error); end
   endtask

   initial begin
      test_reset();
      test_simple();
      test_back_to_back();
      test_gaps_zero_len();
      test_random();
      test_reset_mid_packet();
      test_bad_framing();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/message_stream_splitter.md
# message_stream_splitter

Demultiplexes one combined word stream, as produced by `message_stream_combiner`, back into `N_STREAMS` logical streams. The block parses the packet headers, then routes each payload word to a shared data bus with a one-hot per-stream valid strobe. It sits at the receiving end of a combined link, for example a host-side or loopback bench that separates the sample and message streams after a QA chain. It detects malformed framing and raises `error`.

## Interface
- `N_STREAMS`, 2, number of logical streams.
- `LOG_N_STREAMS`, 1, width of the stream-id field; 2**LOG_N_STREAMS >= N_STREAMS.
- `WDTH`, 32, word width.
- `MAX_PACKET_LENGTH`, 64, largest legal payload length in words.
- `MSG_LENGTH_WIDTH`, 7, width of the length field; must hold MAX_PACKET_LENGTH.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  WDTH  combined-stream word.
- `in_nd`  in  1  in_data valid this cycle.
- `out_data`  out  WDTH  payload word; shared across all streams.
- `out_nd`  out  N_STREAMS  one-hot: bit k high means out_data belongs to stream k.
- `error`  out  1  framing error indicator.

## Operation
- Header word format:
  - bit WDTH-1 = 1 (header flag).
  - bits [WDTH-2 -: LOG_N_STREAMS] = stream id.
  - bits [MSG_LENGTH_WIDTH-1:0] = payload length L.
  - All other bits are ignored.
- Payload words are arbitrary; their flag bit is not checked.
- FSM states: IDLE, PAYLOAD, ERROR.
- IDLE, on in_nd:
  - Flag=0, id>=N_STREAMS, or L>MAX_PACKET_LENGTH -> ERROR.
  - L=0 -> stay in IDLE; nothing is emitted.
  - Otherwise latch the id, load `remaining`=L, go to PAYLOAD.
  - The header word is never forwarded.
- PAYLOAD, on in_nd:
  - Register out_data=in_data and out_nd=onehot(id).
  - Decrement `remaining`; at remaining==1 the transition to IDLE coincides with the last word.
- in_nd low in any state: no state change, out_nd=0. Gaps inside a packet are legal and unbounded.
- ERROR: out_nd held at 0, all input ignored, error=1. Exit only by reset (see Configuration).
- At most one out_nd bit is high in any cycle.
- `remaining` is MSG_LENGTH_WIDTH bits wide and never wraps; the length check guarantees this.

## Timing
- Reset values: out_data=0, out_nd=0, error=0, state=IDLE, remaining=0, latched id=0.
- Latency is one cycle: a payload word accepted at edge n appears on out_data/out_nd after edge n, valid for exactly one cycle.
- error asserts the cycle after the offending word is accepted.
- Back-to-back packets:
  - A header may immediately follow the last payload word.
  - The first payload word of the next packet may appear on the cycle after its header, so throughput is one word per cycle apart from header cycles.
- Reset mid-packet: the partial packet is discarded and the next accepted word is treated as a header.
- out_data holds its last value when out_nd=0; consumers qualify on out_nd.

## Configuration
- `MESSAGE_STREAM_SPLITTER_RESYNC_EN` defined:
  - error is a one-cycle pulse; ERROR state does not exist.
  - The FSM returns to IDLE, and the next word with in_nd is evaluated as a header.
  - Words are dropped until a legal header arrives; each further illegal word pulses error again.
- Macro undefined: error is sticky until rst_n is asserted, as described under Operation.

## Structure
- Shared package `sdrlib_stream_pkg` holds:
  - header flag bit position and field position/width helpers;
  - FSM state encoding;
  - the ERRORCODE constant, shared with the combiner.
- Natural sub-module: `stream_header_decode`, purely combinational. It takes in_data and outputs flag, id, length and header_legal, and is reused by the combiner's testbench.

## Test plan
All scenarios use WDTH=32, N_STREAMS=2, MAX_PACKET_LENGTH=64.
- Simple packet: header 0x8000_0003, then 0x11, 0x22, 0x33 on consecutive cycles -> out_nd=2'b01 for three cycles carrying 0x11, 0x22, 0x33, each one cycle after input; header not emitted; error=0.
- Stream 1 plus back-to-back: header 0xC000_0002, then 0xA, 0xB, then immediately 0x8000_0001, 0xC -> 0xA/0xB with out_nd=2'b10, then 0xC with out_nd=2'b01.
- Gaps and zero length:
  - Header 0x8000_0002, word 0x1, 5 idle cycles, word 0x2 -> out_nd pulses exactly twice.
  - Header 0x8000_0000 followed by 0x8000_0001, 0x7 -> only 0x7 is emitted.
- Bad framing:
  - Word 0x0000_0005 in IDLE -> error=1 next cycle. Without the macro, a following 0x8000_0001, 0x9 produces no output and error stays 1. With the macro, error pulses once and 0x9 is emitted on stream 0.
  - Header length 65 (0x8000_0041) -> error.
- Reset mid-packet: header 0x8000_0004, two payload words, assert rst_n low for 1 cycle -> all outputs 0 immediately; then 0x8000_0001, 0x5 yields 0x5 on stream 0.
